// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle for the hazard/stall controller: register tags and events in,
// pause/flush/forward controls, halt state and performance counters out.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [4:0]       idex_rs;
  logic [4:0]       idex_rt;
  logic             idex_memread;
  logic [4:0]       idex_rw;
  logic             exmem_regwrite;
  logic [4:0]       exmem_rw;
  logic             memwb_regwrite;
  logic [4:0]       memwb_rw;
  logic             halt_wb;
  logic             ex_branch_taken;
  logic             mem_busy;
  logic             pause_pc;
  logic             pause_ifid;
  logic             pause_idex;
  logic             pause_exmem;
  logic             pause_memwb;
  logic             flush_ifid;
  logic             flush_idex;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             halted;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, idex_rs, idex_rt, idex_memread, idex_rw,
           exmem_regwrite, exmem_rw, memwb_regwrite, memwb_rw, halt_wb, ex_branch_taken,
           mem_busy,
    input  pause_pc, pause_ifid, pause_idex, pause_exmem, pause_memwb, flush_ifid,
           flush_idex, fwd_a, fwd_b, halted, cycle_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, idex_rs, idex_rt, idex_memread, idex_rw,
           exmem_regwrite, exmem_rw, memwb_regwrite, memwb_rw, halt_wb, ex_branch_taken,
           mem_busy,
    output pause_pc, pause_ifid, pause_idex, pause_exmem, pause_memwb, flush_ifid,
           flush_idex, fwd_a, fwd_b, halted, cycle_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Central hazard/stall controller for the 5-stage pipeline: pause/flush generation,
// operand forwarding, halt latching and saturating performance counters.
module hazard_stall_ctrl #(
  parameter int CNT_W = 32
) (
  input logic              clk,
  input logic              rst,
  hazard_stall_ctrl_if.slave bus
);
  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cycle_cnt_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             halted_s;
  logic             frz_s;
  logic             lu_s;
  logic             sel_br_s;
  logic             sel_lu_s;
  logic [6:0]       ctrl_s;

  // EX/MEM result beats MEM/WB data; register 0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic ex_we, input logic [4:0] ex_rw,
                                         input logic wb_we, input logic [4:0] wb_rw,
                                         input logic [4:0] src);
    logic [1:0] sel;
    if (ex_we && (ex_rw != 5'd0) && (ex_rw == src)) begin
      sel = 2'b10;
    end else if (wb_we && (wb_rw != 5'd0) && (wb_rw == src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    logic [CNT_W-1:0] res;
    if (val == CNT_MAX) begin
      res = val;
    end else begin
      res = val + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  assign halted_s = (state_r == HALTED);
  assign frz_s    = bus.mem_busy | halted_s | bus.halt_wb;
  assign lu_s     = bus.idex_memread && (bus.idex_rw != 5'd0) &&
                    ((bus.id_use_rs && (bus.id_rs == bus.idex_rw)) ||
                     (bus.id_use_rt && (bus.id_rt == bus.idex_rw)));
  assign sel_br_s = !frz_s && bus.ex_branch_taken;
  assign sel_lu_s = !frz_s && !bus.ex_branch_taken && lu_s;

  // Next-state: halt latches only once writeback is not stalled by memory.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (bus.halt_wb && !bus.mem_busy) begin
          state_nxt_s = HALTED;
        end else begin
          state_nxt_s = RUN;
        end
      end
      HALTED:  state_nxt_s = HALTED;
      default: state_nxt_s = RUN;
    endcase
  end

  // Pause/flush priority: freeze, then branch squash, then load-use bubble.
  // ctrl_s = {pause_pc, pause_ifid, pause_idex, pause_exmem, pause_memwb, flush_ifid, flush_idex}
  always_comb begin
    ctrl_s = 7'b000_0000;
    if (frz_s) begin
      ctrl_s = 7'b111_1100;
    end else if (sel_br_s) begin
      ctrl_s = 7'b000_0011;
    end else if (sel_lu_s) begin
      ctrl_s = 7'b110_0001;
    end else begin
      ctrl_s = 7'b000_0000;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Performance counters advance only while running and hold at their maximum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_r <= {CNT_W{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == RUN) begin
      cycle_cnt_r <= sat_inc(cycle_cnt_r);
      if (sel_lu_s) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
      if (sel_br_s) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end
    end
  end

  assign {bus.pause_pc, bus.pause_ifid, bus.pause_idex, bus.pause_exmem, bus.pause_memwb,
          bus.flush_ifid, bus.flush_idex} = ctrl_s;
  assign bus.fwd_a     = fwd_sel(bus.exmem_regwrite, bus.exmem_rw, bus.memwb_regwrite,
                                 bus.memwb_rw, bus.idex_rs);
  assign bus.fwd_b     = fwd_sel(bus.exmem_regwrite, bus.exmem_rw, bus.memwb_regwrite,
                                 bus.memwb_rw, bus.idex_rt);
  assign bus.halted    = halted_s;
  assign bus.cycle_cnt = cycle_cnt_r;
  assign bus.stall_cnt = stall_cnt_r;
  assign bus.flush_cnt = flush_cnt_r;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_hazard_stall_ctrl;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  int   m_cycle;
  int   m_stall;
  int   m_flush;
  bit   m_halted;

  hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_stall_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which pipeline action the rules demand right now
  function automatic bit m_frz();
    return bus.mem_busy || m_halted || bus.halt_wb;
  endfunction

  function automatic bit m_lu();
    int d;
    d = int'(bus.idex_rw);
    if (!bus.idex_memread || d == 0) return 1'b0;
    if (bus.id_use_rs && int'(bus.id_rs) == d) return 1'b1;
    if (bus.id_use_rt && int'(bus.id_rt) == d) return 1'b1;
    return 1'b0;
  endfunction

  // {pause_pc, pause_ifid, pause_idex, pause_exmem, pause_memwb, flush_ifid, flush_idex}
  function automatic logic [6:0] exp_ctrl();
    if (m_frz()) return 7'b111_1100;
    if (bus.ex_branch_taken) return 7'b000_0011;
    if (m_lu()) return 7'b110_0001;
    return 7'b000_0000;
  endfunction

  function automatic int exp_fwd(input int src);
    if (bus.exmem_regwrite && bus.exmem_rw != 5'd0 && int'(bus.exmem_rw) == src) return 2;
    if (bus.memwb_regwrite && bus.memwb_rw != 5'd0 && int'(bus.memwb_rw) == src) return 1;
    return 0;
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic check_all();
    chk("ctrl", {bus.pause_pc, bus.pause_ifid, bus.pause_idex, bus.pause_exmem,
                 bus.pause_memwb, bus.flush_ifid, bus.flush_idex}, exp_ctrl());
    chk("fwd_a", bus.fwd_a, exp_fwd(int'(bus.idex_rs)));
    chk("fwd_b", bus.fwd_b, exp_fwd(int'(bus.idex_rt)));
    chk("halted", bus.halted, m_halted);
    chk("cycle_cnt", bus.cycle_cnt, m_cycle);
    chk("stall_cnt", bus.stall_cnt, m_stall);
    chk("flush_cnt", bus.flush_cnt, m_flush);
  endtask

  // One cycle: compare at negedge, advance the model at posedge, then move off the edge.
  task automatic tick();
    bit frz;
    bit br;
    bit lu;
    @(negedge clk);
    check_all();
    frz = m_frz();
    br  = bus.ex_branch_taken;
    lu  = m_lu();
    @(posedge clk);
    if (rst && !m_halted) begin
      m_cycle = sat(m_cycle);
      if (!frz && br) m_flush = sat(m_flush);
      else if (!frz && lu) m_stall = sat(m_stall);
      if (bus.halt_wb && !bus.mem_busy) m_halted = 1'b1;
    end
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0;
    bus.idex_rs = 5'd0; bus.idex_rt = 5'd0; bus.idex_memread = 1'b0; bus.idex_rw = 5'd0;
    bus.exmem_regwrite = 1'b0; bus.exmem_rw = 5'd0;
    bus.memwb_regwrite = 1'b0; bus.memwb_rw = 5'd0;
    bus.halt_wb = 1'b0; bus.ex_branch_taken = 1'b0; bus.mem_busy = 1'b0;
  endtask

  // Asynchronous reset pulse placed mid-cycle; the clear must be visible before any edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_halted", bus.halted, 0);
    chk("rst_cycle", bus.cycle_cnt, 0);
    chk("rst_stall", bus.stall_cnt, 0);
    chk("rst_flush", bus.flush_cnt, 0);
    m_cycle = 0; m_stall = 0; m_flush = 0; m_halted = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic rand_inputs();
    bus.id_rs = 5'($urandom_range(0, 3));
    bus.id_rt = 5'($urandom_range(0, 3));
    bus.id_use_rs = 1'($urandom_range(0, 1));
    bus.id_use_rt = 1'($urandom_range(0, 1));
    bus.idex_rs = 5'($urandom_range(0, 3));
    bus.idex_rt = 5'($urandom_range(0, 3));
    bus.idex_memread = 1'($urandom_range(0, 1));
    bus.idex_rw = 5'($urandom_range(0, 3));
    bus.exmem_regwrite = 1'($urandom_range(0, 1));
    bus.exmem_rw = 5'($urandom_range(0, 3));
    bus.memwb_regwrite = 1'($urandom_range(0, 1));
    bus.memwb_rw = 5'($urandom_range(0, 3));
    bus.halt_wb = ($urandom_range(0, 99) < 2);
    bus.ex_branch_taken = ($urandom_range(0, 99) < 15);
    bus.mem_busy = ($urandom_range(0, 99) < 20);
  endtask

  initial begin
    int halt_wait;
    tests = 0; failed = 0;
    m_cycle = 0; m_stall = 0; m_flush = 0; m_halted = 1'b0;
    rst = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst = 1'b1;

    // Idle after reset
    repeat (10) tick();
    chk("idle_cycle", bus.cycle_cnt, 10);
    chk("idle_stall", bus.stall_cnt, 0);
    chk("idle_flush", bus.flush_cnt, 0);
    chk("idle_halted", bus.halted, 0);
    chk("idle_fwd_a", bus.fwd_a, 0);

    // Forwarding priority and register 0
    bus.exmem_regwrite = 1'b1; bus.memwb_regwrite = 1'b1;
    bus.exmem_rw = 5'd5; bus.memwb_rw = 5'd5; bus.idex_rs = 5'd5;
    #1 chk("fwd_exmem", bus.fwd_a, 2);
    bus.exmem_regwrite = 1'b0;
    #1 chk("fwd_memwb", bus.fwd_a, 1);
    bus.exmem_regwrite = 1'b1; bus.exmem_rw = 5'd0; bus.memwb_rw = 5'd0;
    #1 chk("fwd_r0", bus.fwd_a, 0);
    tick();
    clear_inputs();

    // Load-use bubble, then the same hazard squashed by a taken branch
    bus.idex_memread = 1'b1; bus.idex_rw = 5'd8; bus.id_rt = 5'd8; bus.id_use_rt = 1'b1;
    #1 chk("lu_ctrl", {bus.pause_pc, bus.pause_ifid, bus.pause_idex, bus.pause_exmem,
                       bus.pause_memwb, bus.flush_ifid, bus.flush_idex}, 7'b110_0001);
    tick();
    chk("lu_stall", bus.stall_cnt, 1);
    bus.ex_branch_taken = 1'b1;
    #1 chk("br_ctrl", {bus.pause_pc, bus.pause_ifid, bus.pause_idex, bus.pause_exmem,
                       bus.pause_memwb, bus.flush_ifid, bus.flush_idex}, 7'b000_0011);
    tick();
    chk("br_flush", bus.flush_cnt, 1);
    chk("br_stall", bus.stall_cnt, 1);

    // Memory busy freezes a pending load-use hazard
    bus.ex_branch_taken = 1'b0; bus.mem_busy = 1'b1;
    repeat (3) begin
      #1 chk("busy_ctrl", {bus.pause_pc, bus.pause_ifid, bus.pause_idex, bus.pause_exmem,
                           bus.pause_memwb, bus.flush_ifid, bus.flush_idex}, 7'b111_1100);
      tick();
    end
    chk("busy_stall", bus.stall_cnt, 1);
    chk("busy_cycle", bus.cycle_cnt, 16);

    // Halt deferred by memory busy
    clear_inputs();
    bus.halt_wb = 1'b1; bus.mem_busy = 1'b1;
    repeat (2) tick();
    chk("halt_deferred", bus.halted, 0);
    bus.mem_busy = 1'b0;
    #1 chk("halt_ctrl", {bus.pause_pc, bus.pause_ifid, bus.pause_idex, bus.pause_exmem,
                         bus.pause_memwb, bus.flush_ifid, bus.flush_idex}, 7'b111_1100);
    tick();
    chk("halted_set", bus.halted, 1);
    bus.halt_wb = 1'b0; bus.ex_branch_taken = 1'b1;
    repeat (3) tick();
    chk("halt_cycle", bus.cycle_cnt, 19);
    chk("halt_flush", bus.flush_cnt, 1);
    chk("halt_pause", bus.pause_pc, 1);
    do_reset();
    clear_inputs();
    repeat (2) tick();
    chk("post_rst_cycle", bus.cycle_cnt, 2);

    // Randomized traffic with occasional resets, including out of HALTED
    halt_wait = 0;
    for (int i = 0; i < 700; i++) begin
      rand_inputs();
      tick();
      if (m_halted) halt_wait++;
      if (halt_wait >= 4 || $urandom_range(0, 199) == 0) begin
        halt_wait = 0;
        do_reset();
      end
    end

    // Counter saturation
    clear_inputs();
    do_reset();
    bus.ex_branch_taken = 1'b1;
    repeat (CMAX + 20) tick();
    chk("sat_flush", bus.flush_cnt, 255);
    chk("sat_cycle", bus.cycle_cnt, 255);
    bus.ex_branch_taken = 1'b0;
    bus.idex_memread = 1'b1; bus.idex_rw = 5'd3; bus.id_rs = 5'd3; bus.id_use_rs = 1'b1;
    repeat (CMAX + 20) tick();
    chk("sat_stall", bus.stall_cnt, 255);
    chk("sat_flush_hold", bus.flush_cnt, 255);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Central hazard and stall controller for the 5-stage pipeline. It generates the pause and flush controls consumed by every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB), selects the forwarding paths, and latches the halt state once a halt instruction reaches writeback. It also keeps registered performance counters for cycles, load-use stalls and branch flushes.

Parameters:
CNT_W, 32, width of each performance counter; counters saturate at 2^CNT_W-1.

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-low reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
idex_rs  in  5  rs held in ID/EX
idex_rt  in  5  rt held in ID/EX
idex_memread  in  1  ID/EX instruction is a load (MemToReg)
idex_rw  in  5  destination register in ID/EX
exmem_regwrite  in  1  EX/MEM RegWrite
exmem_rw  in  5  EX/MEM destination register
memwb_regwrite  in  1  MEM/WB RegWrite
memwb_rw  in  5  MEM/WB destination register
halt_wb  in  1  halt flag at MEM/WB output
ex_branch_taken  in  1  branch or jump resolved taken in EX
mem_busy  in  1  data memory not ready this cycle
pause_pc, pause_ifid, pause_idex, pause_exmem, pause_memwb  out  1 each  hold the corresponding register
flush_ifid, flush_idex  out  1 each  load a bubble (all fields 0) into the register
fwd_a, fwd_b  out  2 each  ALU operand source: 00 regfile, 10 EX/MEM result, 01 MEM/WB writeback data
halted  out  1  processor halted (registered)
cycle_cnt, stall_cnt, flush_cnt  out  CNT_W each  registered counters

Behaviour:
- Reset (rst=0, asynchronous): state is RUN, halted=0, and all counters are 0. Combinational outputs follow their equations.
- State machine:
  - RUN -> HALTED when halt_wb=1 and mem_busy=0, at the clock edge.
  - HALTED is left only by reset.
  - halted=1 exactly in HALTED.
- Forwarding (combinational, same cycle):
  - fwd_a=10 if exmem_regwrite, exmem_rw!=0 and exmem_rw==idex_rs.
  - Otherwise fwd_a=01 if memwb_regwrite, memwb_rw!=0 and memwb_rw==idex_rs.
  - Otherwise fwd_a=00.
  - fwd_b is computed the same way using idex_rt.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- Load-use condition lu: idex_memread, idex_rw!=0, and ((id_use_rs and id_rs==idex_rw) or (id_use_rt and id_rt==idex_rw)).
- Freeze condition frz: mem_busy or halted or halt_wb.
- Output priority, highest first:
  1. frz: all five pauses=1, both flushes=0.
  2. ex_branch_taken: flush_ifid=1, flush_idex=1, all pauses=0. The branch suppresses lu because the stalled instruction is squashed.
  3. lu: pause_pc=1, pause_ifid=1, flush_idex=1, all other controls 0. This costs exactly one bubble per load-use pair.
  4. Otherwise all pauses and flushes are 0.
- Counters, updated at the clock edge and only in RUN:
  - cycle_cnt increments every RUN cycle.
  - stall_cnt increments when case 3 is selected.
  - flush_cnt increments when case 2 is selected.
  - No counter increments when frz=1, except cycle_cnt.
  - Each counter saturates at its maximum and holds; there is no wrap-around.
  - In HALTED all counters freeze.
- Simultaneous events:
  - mem_busy together with a branch or lu: the freeze wins, and the branch or stall is re-evaluated next cycle because the inputs are held.
  - halt_wb together with mem_busy: the halt is deferred until mem_busy=0.
- Reset asserted mid-stall or while HALTED returns the block to RUN immediately. Counters clear asynchronously.

Test Plan:
- Reset then 10 idle cycles -> halted=0, pauses and flushes 0, fwd=00, cycle_cnt=10, stall_cnt=0, flush_cnt=0.
- Forwarding with exmem_rw=5, memwb_rw=5, idex_rs=5, both regwrite=1 -> fwd_a=10. With exmem_regwrite=0 -> fwd_a=01. With rw=0 -> fwd_a=00.
- Load-use with idex_memread=1, idex_rw=8, id_rt=8, id_use_rt=1 -> pause_pc=pause_ifid=flush_idex=1 for one cycle, stall_cnt +1. Same inputs with ex_branch_taken=1 -> flushes only, flush_cnt +1, stall_cnt unchanged.
- mem_busy=1 for 3 cycles during load-use -> all pauses=1, no flush, stall_cnt unchanged, cycle_cnt +3.
- halt_wb=1 with mem_busy=1 for 2 cycles, then mem_busy=0 -> halted rises one edge after mem_busy falls, all pauses stay 1, counters frozen.
- rst pulsed low while HALTED with counters nonzero -> halted=0 and counters 0 without waiting for a clock edge; normal operation resumes.
